// File: rtl/sum_job_scheduler_if.sv
// sum_job_scheduler_if: requester-side bundle of the shared sum-of-naturals engine.
// Handshake: each requester raises req[i] (level) with its operand on n_in[i*NW +: NW]
// and holds it until it sees gnt[i] pulse for one cycle; n is captured on that grant
// edge. A result is presented by a one-cycle done pulse that qualifies done_id and
// s_out; there is no backpressure on results.
interface sum_job_scheduler_if #(
  parameter int NREQ = 2,
  parameter int NW   = 4,
  parameter int SW   = 7
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*NW-1:0] n_in;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               done;
  logic [IDW-1:0]     done_id;
  logic [SW-1:0]      s_out;

  modport master (output req, n_in, input gnt, busy, done, done_id, s_out);
  modport slave  (input req, n_in, output gnt, busy, done, done_id, s_out);
endinterface

// File: rtl/sum_job_scheduler.sv
// sum_job_scheduler: round-robin shares one sum-of-naturals engine (1+2+...+n)
// between NREQ requesters; one job in flight at a time.
// Optional build macro SUM_CLOSED_FORM_EN: single-cycle n*(n+1)/2 instead of the
// iterative accumulate. Ports, states, results and arbitration are the same.
module sum_job_scheduler #(
  parameter int NREQ = 2,
  parameter int NW   = 4,
  parameter int SW   = 7
) (
  input  logic                clk,
  input  logic                rst,
  sum_job_scheduler_if.slave  bus,
  output logic [1:0]          dbg_state
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id;
  logic [IDW-1:0]  winner;
  logic [NW-1:0]   n_sel;
  logic [NW-1:0]   cnt;
  logic [NREQ-1:0] gnt_r;
  logic            done_r;
  logic [IDW-1:0]  done_id_r;
  logic [SW-1:0]   s_r;
  int              idx;
  logic            found;

  assign bus.gnt     = gnt_r;
  assign bus.done    = done_r;
  assign bus.done_id = done_id_r;
  assign bus.s_out   = s_r;
  assign bus.busy    = (state != S_IDLE);
  assign dbg_state   = state;

  // Round-robin pick: first pending requester after the last one served, wrapping.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        winner = idx[IDW-1:0];
        found  = 1'b1;
      end
    end
    n_sel = bus.n_in[int'(winner)*NW +: NW];
  end

`ifdef SUM_CLOSED_FORM_EN
  logic [SW:0] n_ext;
  logic [SW:0] tri_sum;

  // Closed-form triangular number, one bit wider than the result before truncation.
  always_comb begin
    n_ext   = (SW+1)'(cnt);
    tri_sum = (n_ext * (n_ext + (SW+1)'(1))) >> 1;
  end

  // Control FSM: arbitrate in IDLE, produce the result in a single ACC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= IDW'(NREQ-1);
      id        <= '0;
      cnt       <= '0;
      gnt_r     <= '0;
      done_r    <= 1'b0;
      done_id_r <= '0;
      s_r       <= '0;
    end else begin
      gnt_r  <= '0;
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            gnt_r <= NREQ'(1) << winner;
            id    <= winner;
            cnt   <= n_sel;
            ptr   <= winner;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          s_r       <= tri_sum[SW-1:0];
          done_id_r <= id;
          done_r    <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  logic [SW-1:0] acc;

  // Control FSM: arbitrate in IDLE, add cnt, cnt-1, ... 1 in ACC, report in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= IDW'(NREQ-1);
      id        <= '0;
      cnt       <= '0;
      acc       <= '0;
      gnt_r     <= '0;
      done_r    <= 1'b0;
      done_id_r <= '0;
      s_r       <= '0;
    end else begin
      gnt_r  <= '0;
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            gnt_r <= NREQ'(1) << winner;
            id    <= winner;
            cnt   <= n_sel;
            acc   <= '0;
            ptr   <= winner;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          if (cnt != '0) begin
            acc <= acc + SW'(cnt);
            cnt <= cnt - NW'(1);
          end else begin
            s_r       <= acc;
            done_id_r <= id;
            done_r    <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
`endif
endmodule
